// File: rtl/uc_irq_if.sv
// Bus between program memory / datapath and the interrupt-capable control unit.
// The slave side is the control unit; the master side feeds it instructions,
// flags and interrupt lines and consumes the decoded controls.
interface uc_irq_if #(
  parameter int N_IRQ = 2,
  parameter int AW    = 10
);
  logic [15:0]      opcode;
  logic             z;
  logic [N_IRQ-1:0] intr;

  logic             s_inc;
  logic             we3;
  logic             wez;
  logic             pop;
  logic             push;
  logic             s_stack;
  logic             we4;
  logic             we_out;
  logic             s_vec;
  logic [1:0]       s_inm;
  logic [1:0]       s_in;
  logic [1:0]       s_out;
  logic [2:0]       op_alu;
  logic [AW-1:0]    vec_addr;
  logic [N_IRQ-1:0] irq_ack;
  logic             in_isr;

  modport master (
    output opcode, z, intr,
    input  s_inc, we3, wez, pop, push, s_stack, we4, we_out, s_vec,
    input  s_inm, s_in, s_out, op_alu, vec_addr, irq_ack, in_isr
  );

  modport slave (
    input  opcode, z, intr,
    output s_inc, we3, wez, pop, push, s_stack, we4, we_out, s_vec,
    output s_inm, s_in, s_out, op_alu, vec_addr, irq_ack, in_isr
  );
endinterface

// File: rtl/uc_irq.sv
// Control unit for the single-cycle CPU: combinational opcode decode plus a
// small interrupt sequencer (edge-detected requests, fixed priority, vectored
// entry through the return stack, global enable and RETI).
module uc_irq #(
  parameter int          N_IRQ      = 2,
  parameter int          AW         = 10,
  parameter int unsigned VEC_BASE   = 'h3C0,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  uc_irq_if.slave bus
);

  localparam int SELW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [5:0] F_EI   = 6'b101101;
  localparam logic [5:0] F_DI   = 6'b101110;
  localparam logic [5:0] F_RETI = 6'b101111;

  typedef enum logic [1:0] {RUN, ENTRY, ISR} state_e;

  state_e            state_q, state_d;
  logic [N_IRQ-1:0]  intr_q;
  logic [N_IRQ-1:0]  pend_q, pend_d;
  logic              ie_q, ie_d;
  logic              in_isr_q, in_isr_d;
  logic [SELW-1:0]   sel_q, sel_d;

  logic [5:0]        f;
  logic [N_IRQ-1:0]  rise;
  logic [SELW-1:0]   win_id;

  logic              dec_s_inc, dec_we3, dec_wez, dec_pop, dec_push;
  logic              dec_s_stack, dec_we4, dec_we_out;
  logic [1:0]        dec_s_inm, dec_s_in, dec_s_out;
  logic [2:0]        dec_op_alu;

  logic              unused_ok;

  assign f         = bus.opcode[15:10];
  assign rise      = bus.intr & ~intr_q;
  assign unused_ok = ^bus.opcode[7:0];

  // Plain instruction decode; anything not listed behaves as a NOP.
  always_comb begin
    dec_s_inc   = 1'b1;
    dec_we3     = 1'b0;
    dec_wez     = 1'b0;
    dec_pop     = 1'b0;
    dec_push    = 1'b0;
    dec_s_stack = 1'b0;
    dec_we4     = 1'b0;
    dec_we_out  = 1'b0;
    dec_s_inm   = 2'b00;
    dec_s_in    = 2'b00;
    dec_s_out   = 2'b00;
    dec_op_alu  = 3'b000;
    casez (f)
      6'b0?????: begin
        dec_we3    = 1'b1;
        dec_wez    = 1'b1;
        dec_op_alu = bus.opcode[14:12];
      end
      6'b1000??: begin
        dec_we3   = 1'b1;
        dec_s_inm = 2'b01;
      end
      6'b100100: dec_s_inc = 1'b0;
      6'b100101: dec_s_inc = ~bus.z;
      6'b100110: dec_s_inc = bus.z;
      6'b101000, 6'b101111: begin
        dec_s_inc   = 1'b0;
        dec_pop     = 1'b1;
        dec_s_stack = 1'b1;
      end
      6'b101001: begin
        dec_s_inc = 1'b0;
        dec_push  = 1'b1;
      end
      6'b101010: begin
        dec_we3   = 1'b1;
        dec_s_inm = 2'b11;
        dec_s_in  = bus.opcode[9:8];
      end
      6'b101011: dec_we_out = 1'b1;
      6'b101100: begin
        dec_we_out = 1'b1;
        dec_s_out  = 2'b01;
      end
      6'b1110??: dec_we4 = 1'b1;
      6'b1111??: begin
        dec_we3   = 1'b1;
        dec_s_inm = 2'b10;
      end
      default: ;
    endcase
  end

  // Pick the lowest-numbered pending line.
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) win_id = SELW'(i);
    end
  end

  // Sequencer next state: enable/ISR flags, pending set/clear and FSM moves.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ie_d     = ie_q;
    in_isr_d = in_isr_q;
    sel_d    = sel_q;
    case (state_q)
      RUN, ISR: begin
        if (f == F_EI) ie_d = 1'b1;
        if (f == F_DI) ie_d = 1'b0;
        if (f == F_RETI) begin
          ie_d     = 1'b1;
          in_isr_d = 1'b0;
        end
        if (state_q == RUN) begin
          if (ie_q && (|pend_q) && (f != F_DI)) begin
            state_d = ENTRY;
            sel_d   = win_id;
          end
        end else if (f == F_RETI) begin
          state_d = RUN;
        end
      end
      ENTRY: begin
        for (int i = 0; i < N_IRQ; i++) begin
          if (sel_q == SELW'(i)) pend_d[i] = 1'b0;
        end
        ie_d     = 1'b0;
        in_isr_d = 1'b1;
        state_d  = ISR;
      end
      default: state_d = RUN;
    endcase
    pend_d = pend_d | rise;
  end

  // Output mux: ENTRY replaces the fetched instruction with a vectored call.
  always_comb begin
    bus.s_inc   = dec_s_inc;
    bus.we3     = dec_we3;
    bus.wez     = dec_wez;
    bus.pop     = dec_pop;
    bus.push    = dec_push;
    bus.s_stack = dec_s_stack;
    bus.we4     = dec_we4;
    bus.we_out  = dec_we_out;
    bus.s_vec   = 1'b0;
    bus.s_inm   = dec_s_inm;
    bus.s_in    = dec_s_in;
    bus.s_out   = dec_s_out;
    bus.op_alu  = dec_op_alu;
    bus.irq_ack = '0;
    if (state_q == ENTRY) begin
      bus.s_inc   = 1'b0;
      bus.we3     = 1'b0;
      bus.wez     = 1'b0;
      bus.pop     = 1'b0;
      bus.push    = 1'b1;
      bus.s_stack = 1'b0;
      bus.we4     = 1'b0;
      bus.we_out  = 1'b0;
      bus.s_vec   = 1'b1;
      bus.s_inm   = 2'b00;
      bus.s_in    = 2'b00;
      bus.s_out   = 2'b00;
      bus.op_alu  = 3'b000;
      for (int i = 0; i < N_IRQ; i++) begin
        bus.irq_ack[i] = (sel_q == SELW'(i));
      end
    end
  end

  assign bus.in_isr   = in_isr_q;
  assign bus.vec_addr = AW'(VEC_BASE) + AW'(AW'(sel_q) * AW'(VEC_STRIDE));

  // State registers; intr_q resets high so lines held high through reset never request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      intr_q   <= '1;
      pend_q   <= '0;
      ie_q     <= 1'b0;
      in_isr_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      intr_q   <= bus.intr;
      pend_q   <= pend_d;
      ie_q     <= ie_d;
      in_isr_q <= in_isr_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_uc_irq.sv
// Self-checking bench for uc_irq: directed interrupt scenarios plus random
// instruction/request streams, all compared against a behavioural model.
module tb_uc_irq;
  localparam int N_IRQ = 2;
  localparam int AW    = 10;

  localparam logic [15:0] OP_NOP  = 16'h9C00;
  localparam logic [15:0] OP_EI   = 16'hB400;
  localparam logic [15:0] OP_DI   = 16'hB800;
  localparam logic [15:0] OP_RETI = 16'hBC00;
  localparam logic [15:0] OP_ST   = 16'hE000;

  typedef struct packed {
    logic       s_inc, we3, wez, pop, push, s_stack, we4, we_out, s_vec;
    logic [1:0] s_inm, s_in, s_out;
    logic [2:0] op_alu;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] curOp;
  logic [1:0]  curIntr;
  logic [1:0]  mPrev, mPend;
  logic        mIe, mInIsr, mEnterNext, mInRoutine;
  int          mSel;

  always #5 clk = ~clk;

  uc_irq_if #(.N_IRQ(N_IRQ), .AW(AW)) bus ();

  uc_irq #(.N_IRQ(N_IRQ), .AW(AW), .VEC_BASE('h3C0), .VEC_STRIDE(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic ctrl_t refDecode(logic [15:0] op, logic zv);
    ctrl_t c;
    int f;
    f = int'(op[15:10]);
    c = '0;
    c.s_inc = 1'b1;
    if (f < 32) begin
      c.we3 = 1'b1; c.wez = 1'b1; c.op_alu = op[14:12];
    end else if (f < 36) begin
      c.we3 = 1'b1; c.s_inm = 2'b01;
    end else if (f == 36) c.s_inc = 1'b0;
    else if (f == 37) c.s_inc = !zv;
    else if (f == 38) c.s_inc = zv;
    else if (f == 40 || f == 47) begin
      c.s_inc = 1'b0; c.pop = 1'b1; c.s_stack = 1'b1;
    end else if (f == 41) begin
      c.s_inc = 1'b0; c.push = 1'b1;
    end else if (f == 42) begin
      c.we3 = 1'b1; c.s_inm = 2'b11; c.s_in = op[9:8];
    end else if (f == 43) c.we_out = 1'b1;
    else if (f == 44) begin
      c.we_out = 1'b1; c.s_out = 2'b01;
    end else if (f >= 56 && f < 60) c.we4 = 1'b1;
    else if (f >= 60) begin
      c.we3 = 1'b1; c.s_inm = 2'b10;
    end
    return c;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mPrev = 2'b11; mPend = 2'b00; mIe = 1'b0; mInIsr = 1'b0;
    mEnterNext = 1'b0; mInRoutine = 1'b0; mSel = 0;
  endtask

  // Drive one instruction after the falling edge and compare against the model.
  task automatic applyStimulus(logic [15:0] op, logic zv, logic [1:0] irqv);
    ctrl_t e, got;
    @(negedge clk);
    bus.opcode = op; bus.z = zv; bus.intr = irqv;
    curOp = op; curIntr = irqv;
    #1;
    if (mEnterNext) begin
      e = '0; e.push = 1'b1; e.s_vec = 1'b1;
    end else begin
      e = refDecode(op, zv);
    end
    got = {bus.s_inc, bus.we3, bus.wez, bus.pop, bus.push, bus.s_stack, bus.we4,
           bus.we_out, bus.s_vec, bus.s_inm, bus.s_in, bus.s_out, bus.op_alu};
    checkOutput("ctrl", 32'(got), 32'(e));
    checkOutput("irq_ack", 32'(bus.irq_ack), mEnterNext ? (32'd1 << mSel) : 32'd0);
    checkOutput("vec_addr", 32'(bus.vec_addr), 32'(10'('h3C0 + mSel * 4)));
    checkOutput("in_isr", 32'(bus.in_isr), 32'(mInIsr));
  endtask

  // Advance the model across the rising edge.
  task automatic clockEdge();
    logic [1:0] rise;
    int f;
    logic start;
    @(posedge clk);
    rise = curIntr & ~mPrev;
    mPrev = curIntr;
    f = int'(curOp[15:10]);
    if (mEnterNext) begin
      mPend[mSel] = 1'b0; mIe = 1'b0; mInIsr = 1'b1; mInRoutine = 1'b1; mEnterNext = 1'b0;
    end else begin
      start = !mInRoutine && mIe && (mPend != 2'b00) && (f != 46);
      if (start) mSel = mPend[0] ? 0 : 1;
      if (f == 45) mIe = 1'b1;
      if (f == 46) mIe = 1'b0;
      if (f == 47) begin
        mIe = 1'b1; mInIsr = 1'b0; mInRoutine = 1'b0;
      end
      mEnterNext = start;
    end
    mPend = mPend | rise;
  endtask

  task automatic cycle(logic [15:0] op, logic zv, logic [1:0] irqv);
    applyStimulus(op, zv, irqv);
    clockEdge();
  endtask

  initial begin
    logic [1:0]  rIntr;
    logic [15:0] rOp;
    int r;
    rst_n = 1'b0; bus.opcode = 16'h0000; bus.z = 1'b0; bus.intr = 2'b00;
    curOp = 16'h0000; curIntr = 2'b00;
    modelReset();
    #1;
    checkOutput("rst_irq_ack", 32'(bus.irq_ack), 32'd0);
    checkOutput("rst_s_vec", 32'(bus.s_vec), 32'd0);
    checkOutput("rst_in_isr", 32'(bus.in_isr), 32'd0);
    checkOutput("rst_vec_addr", 32'(bus.vec_addr), 32'h3C0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Decode sweep over every major opcode, both zero-flag values.
    for (int zz = 0; zz < 2; zz++) begin
      for (int fv = 0; fv < 64; fv++) begin
        rOp = {6'(fv), 10'($urandom_range(0, 1023))};
        applyStimulus(rOp, 1'(zz), 2'b00);
        if (fv == 37) checkOutput("jz_s_inc", 32'(bus.s_inc), (zz == 1) ? 32'd0 : 32'd1);
        clockEdge();
      end
    end
    applyStimulus({6'b101010, 2'b10, 8'h00}, 1'b0, 2'b00);
    checkOutput("in_s_in", 32'(bus.s_in), 32'd2);
    clockEdge();

    // Single request on line 1.
    cycle(OP_EI, 1'b0, 2'b00);
    cycle(OP_NOP, 1'b0, 2'b00);
    cycle(OP_NOP, 1'b0, 2'b10);
    cycle(OP_NOP, 1'b0, 2'b10);
    applyStimulus(OP_NOP, 1'b0, 2'b10);
    checkOutput("single_push", 32'(bus.push), 32'd1);
    checkOutput("single_s_vec", 32'(bus.s_vec), 32'd1);
    checkOutput("single_vec", 32'(bus.vec_addr), 32'h3C4);
    checkOutput("single_ack", 32'(bus.irq_ack), 32'd2);
    clockEdge();
    applyStimulus(OP_NOP, 1'b0, 2'b10);
    checkOutput("single_in_isr", 32'(bus.in_isr), 32'd1);
    clockEdge();
    applyStimulus(OP_RETI, 1'b0, 2'b00);
    checkOutput("reti_pop", 32'(bus.pop), 32'd1);
    checkOutput("reti_s_stack", 32'(bus.s_stack), 32'd1);
    clockEdge();
    applyStimulus(OP_NOP, 1'b0, 2'b00);
    checkOutput("reti_in_isr", 32'(bus.in_isr), 32'd0);
    clockEdge();

    // Two simultaneous requests: line 0 first, line 1 right after RETI.
    cycle(OP_NOP, 1'b0, 2'b11);
    cycle(OP_NOP, 1'b0, 2'b11);
    applyStimulus(OP_NOP, 1'b0, 2'b11);
    checkOutput("prio_vec0", 32'(bus.vec_addr), 32'h3C0);
    checkOutput("prio_ack0", 32'(bus.irq_ack), 32'd1);
    clockEdge();
    cycle(OP_NOP, 1'b0, 2'b11);
    cycle(OP_RETI, 1'b0, 2'b11);
    applyStimulus(OP_NOP, 1'b0, 2'b11);
    checkOutput("prio_gap", 32'(bus.s_vec), 32'd0);
    clockEdge();
    applyStimulus(OP_NOP, 1'b0, 2'b11);
    checkOutput("prio_vec1", 32'(bus.vec_addr), 32'h3C4);
    checkOutput("prio_ack1", 32'(bus.irq_ack), 32'd2);
    clockEdge();
    cycle(OP_NOP, 1'b0, 2'b00);
    cycle(OP_RETI, 1'b0, 2'b00);

    // Masked request waits for EI.
    cycle(OP_DI, 1'b0, 2'b00);
    cycle(OP_NOP, 1'b0, 2'b01);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(OP_NOP, 1'b0, 2'b01);
      checkOutput("mask_no_entry", 32'(bus.s_vec), 32'd0);
      clockEdge();
    end
    cycle(OP_EI, 1'b0, 2'b01);
    cycle(OP_NOP, 1'b0, 2'b01);
    applyStimulus(OP_NOP, 1'b0, 2'b01);
    checkOutput("mask_entry", 32'(bus.s_vec), 32'd1);
    checkOutput("mask_ack", 32'(bus.irq_ack), 32'd1);
    clockEdge();
    cycle(OP_NOP, 1'b0, 2'b00);
    cycle(OP_RETI, 1'b0, 2'b00);

    // Entry lands on a store: it is suppressed and replayed after RETI.
    cycle(OP_NOP, 1'b0, 2'b10);
    cycle(OP_NOP, 1'b0, 2'b10);
    applyStimulus(OP_ST, 1'b0, 2'b10);
    checkOutput("supp_we4", 32'(bus.we4), 32'd0);
    checkOutput("supp_push", 32'(bus.push), 32'd1);
    clockEdge();
    cycle(OP_NOP, 1'b0, 2'b10);
    cycle(OP_RETI, 1'b0, 2'b10);
    applyStimulus(OP_ST, 1'b0, 2'b10);
    checkOutput("replay_we4", 32'(bus.we4), 32'd1);
    checkOutput("replay_push", 32'(bus.push), 32'd0);
    clockEdge();

    // Reset in the middle of a service routine with both lines held high.
    cycle(OP_NOP, 1'b0, 2'b00);
    cycle(OP_NOP, 1'b0, 2'b01);
    cycle(OP_NOP, 1'b0, 2'b01);
    cycle(OP_NOP, 1'b0, 2'b01);
    cycle(OP_NOP, 1'b0, 2'b11);
    applyStimulus(OP_NOP, 1'b0, 2'b11);
    checkOutput("pre_rst_in_isr", 32'(bus.in_isr), 32'd1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_ack", 32'(bus.irq_ack), 32'd0);
    checkOutput("mid_rst_s_vec", 32'(bus.s_vec), 32'd0);
    checkOutput("mid_rst_in_isr", 32'(bus.in_isr), 32'd0);
    checkOutput("mid_rst_vec", 32'(bus.vec_addr), 32'h3C0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cycle(OP_EI, 1'b0, 2'b11);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(OP_NOP, 1'b0, 2'b11);
      checkOutput("rst_held_high", 32'(bus.s_vec), 32'd0);
      clockEdge();
    end
    cycle(OP_NOP, 1'b0, 2'b00);
    cycle(OP_NOP, 1'b0, 2'b01);
    cycle(OP_NOP, 1'b0, 2'b01);
    applyStimulus(OP_NOP, 1'b0, 2'b01);
    checkOutput("rst_new_edge", 32'(bus.s_vec), 32'd1);
    clockEdge();
    cycle(OP_NOP, 1'b0, 2'b00);
    cycle(OP_RETI, 1'b0, 2'b00);

    // Random instruction and request streams.
    rIntr = 2'b00;
    for (int k = 0; k < 1500; k++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) rOp = OP_RETI;
      else if (r == 1) rOp = OP_EI;
      else if (r == 2) rOp = OP_DI;
      else rOp = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rIntr = 2'($urandom);
      cycle(rOp, 1'($urandom), rIntr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
